// File: rtl/mux16_scan_serializer.sv
// mux16_scan_serializer
// Upstream controller for a combinational 16:1 mux. Captures a 16-bit word on
// a valid/ready handshake, parks it on the mux data inputs, walks the mux
// select through all 16 positions and forwards the mux output as a serial
// bitstream with valid/ready/last framing.
module mux16_scan_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic [15:0] mux_din,
  output logic [3:0]  mux_sel,
  input  logic        mux_f,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        ser_data,
  output logic        ser_last,
  output logic        busy
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   din_q, din_d;

  logic                in_shift;
  logic                last_beat;
  logic                end_of_word;
  logic                accept;

  assign in_shift    = (state_q == SHIFT);
  assign last_beat   = in_shift && (cnt_q == CNT_MAX);
  // The final beat frees the word register in the same cycle it is consumed,
  // so a waiting word can be taken with no bubble (ser_ready -> in_ready).
  assign end_of_word = last_beat && ser_ready;
  assign in_ready    = rst_n && ((state_q == IDLE) || end_of_word);
  assign accept      = in_valid && in_ready;

  // Select is a pure function of the registered count, so it changes once per
  // cycle with no combinational hazard from the handshake inputs.
  assign mux_sel   = MSB_FIRST ? (CNT_MAX - cnt_q) : cnt_q;
  assign mux_din   = din_q;
  assign ser_valid = in_shift;
  assign ser_last  = last_beat;
  assign busy      = in_shift;
  // The mux output goes straight downstream; sampling happens at the consumer.
  assign ser_data  = mux_f;

  // Next-state logic: load on accept, advance on each transferred beat,
  // chain or return to IDLE after the 16th beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          din_d   = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            cnt_d = '0;
            if (in_valid) begin
              din_d   = in_data;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, count and word registers; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: tb/tb_mux16_scan_serializer.sv
// Bench for mux16_scan_serializer: one instance per scan order, both driven
// by the same stimulus, each closed around a behavioural 16:1 mux.
module tb_mux16_scan_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        ser_ready = 1'b1;

  logic        in_ready0, in_ready1;
  logic [15:0] mux_din0, mux_din1;
  logic [3:0]  mux_sel0, mux_sel1;
  logic        mux_f0, mux_f1;
  logic        ser_valid0, ser_valid1;
  logic        ser_data0, ser_data1;
  logic        ser_last0, ser_last1;
  logic        busy0, busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mux_f0 = mux_din0[mux_sel0];
  assign mux_f1 = mux_din1[mux_sel1];

  mux16_scan_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .mux_din(mux_din0), .mux_sel(mux_sel0), .mux_f(mux_f0),
    .ser_valid(ser_valid0), .ser_ready(ser_ready), .ser_data(ser_data0),
    .ser_last(ser_last0), .busy(busy0)
  );

  mux16_scan_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .mux_din(mux_din1), .mux_sel(mux_sel1), .mux_f(mux_f1),
    .ser_valid(ser_valid1), .ser_ready(ser_ready), .ser_data(ser_data1),
    .ser_last(ser_last1), .busy(busy1)
  );

  // Expect both instances idle with reset values.
  task automatic check_idle(input string tag);
    checks++; if (ser_valid0 !== 1'b0 || ser_valid1 !== 1'b0) begin failures++; $display("FAIL %s ser_valid got %b/%b want 0/0", tag, ser_valid0, ser_valid1); end
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL %s busy got %b/%b want 0/0", tag, busy0, busy1); end
    checks++; if (ser_last0 !== 1'b0 || ser_last1 !== 1'b0) begin failures++; $display("FAIL %s ser_last got %b/%b want 0/0", tag, ser_last0, ser_last1); end
    checks++; if (mux_sel0 !== 4'd0 || mux_sel1 !== 4'd15) begin failures++; $display("FAIL %s mux_sel got %0d/%0d want 0/15", tag, mux_sel0, mux_sel1); end
  endtask

  // Present a word while idle; it is accepted on the next rising edge.
  task automatic load(input logic [15:0] w);
    @(negedge clk);
    in_valid = 1'b1; in_data = w; ser_ready = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin failures++; $display("FAIL load_in_ready got %b/%b want 1/1", in_ready0, in_ready1); end
  endtask

  // Walk nbeats beats of word w. Optional stall of stall_len cycles at beat
  // stall_at, optional noise on in_valid/in_data, and at beat 15 optionally
  // present the next word (chain) for a bubble-free handover.
  task automatic stream(input logic [15:0] w, input int nbeats, input int stall_at,
                        input int stall_len, input bit noise, input bit chain,
                        input logic [15:0] nxt);
    int stall_left = stall_len;
    int i = 0;
    int cyc = 0;
    while (i < nbeats && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
      end else begin
        in_valid = chain;
      end
      if (i == stall_at && stall_left > 0) begin
        ser_ready = 1'b0; stall_left--;
      end else begin
        ser_ready = 1'b1;
      end
      if (i == 15) begin
        in_valid = chain; in_data = nxt;
      end
      #1;
      checks++; if (ser_valid0 !== 1'b1 || ser_valid1 !== 1'b1) begin failures++; $display("FAIL beat%0d ser_valid got %b/%b want 1/1", i, ser_valid0, ser_valid1); end
      checks++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin failures++; $display("FAIL beat%0d busy got %b/%b want 1/1", i, busy0, busy1); end
      checks++; if (mux_sel0 !== 4'(i) || mux_sel1 !== 4'(15 - i)) begin failures++; $display("FAIL beat%0d mux_sel got %0d/%0d want %0d/%0d", i, mux_sel0, mux_sel1, i, 15 - i); end
      checks++; if (ser_data0 !== w[i] || ser_data1 !== w[15 - i]) begin failures++; $display("FAIL beat%0d ser_data got %b/%b want %b/%b", i, ser_data0, ser_data1, w[i], w[15 - i]); end
      checks++; if (ser_last0 !== (i == 15) || ser_last1 !== (i == 15)) begin failures++; $display("FAIL beat%0d ser_last got %b/%b want %b", i, ser_last0, ser_last1, (i == 15)); end
      checks++; if (mux_din0 !== w || mux_din1 !== w) begin failures++; $display("FAIL beat%0d mux_din got %h/%h want %h", i, mux_din0, mux_din1, w); end
      checks++; if (in_ready0 !== (i == 15 && ser_ready) || in_ready1 !== (i == 15 && ser_ready)) begin failures++; $display("FAIL beat%0d in_ready got %b/%b want %b", i, in_ready0, in_ready1, (i == 15 && ser_ready)); end
      if (ser_ready) i++;
    end
    checks++; if (i != nbeats) begin failures++; $display("FAIL stream_budget got %0d beats want %0d", i, nbeats); end
  endtask

  // Confirm the block returned to IDLE after a word.
  task automatic expect_idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0; ser_ready = 1'b1;
    #1;
    check_idle(tag);
    checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin failures++; $display("FAIL %s in_ready got %b/%b want 1/1", tag, in_ready0, in_ready1); end
  endtask

  task automatic test_reset();
    #2;
    check_idle("reset");
    checks++; if (mux_din0 !== 16'h0000 || mux_din1 !== 16'h0000) begin failures++; $display("FAIL reset_mux_din got %h/%h want 0000", mux_din0, mux_din1); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got %b/%b want 1/1", in_ready0, in_ready1); end
  endtask

  task automatic test_scan_order();
    load(16'hA5C3);
    stream(16'hA5C3, 16, -1, 0, 1'b0, 1'b0, 16'h0000);
    expect_idle("scan_idle");
  endtask

  task automatic test_backpressure();
    load(16'h1234);
    stream(16'h1234, 16, 4, 3, 1'b0, 1'b0, 16'h0000);
    expect_idle("bp_idle");
  endtask

  task automatic test_back_to_back();
    load(16'hFFFF);
    stream(16'hFFFF, 16, -1, 0, 1'b0, 1'b1, 16'h0000);
    stream(16'h0000, 16, -1, 0, 1'b0, 1'b0, 16'h0000);
    expect_idle("b2b_idle");
  endtask

  task automatic test_reset_mid_word();
    load(16'hC35A);
    stream(16'hC35A, 7, -1, 0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    checks++; if (mux_din0 !== 16'h0000 || mux_din1 !== 16'h0000) begin failures++; $display("FAIL midrst_mux_din got %h/%h want 0000", mux_din0, mux_din1); end
    @(posedge clk);
    #1;
    checks++; if (ser_last0 !== 1'b0 || ser_last1 !== 1'b0 || ser_valid0 !== 1'b0) begin failures++; $display("FAIL midrst_hold got last %b/%b valid %b want 0", ser_last0, ser_last1, ser_valid0); end
    @(negedge clk);
    rst_n = 1'b1;
    load(16'h8001);
    stream(16'h8001, 16, -1, 0, 1'b0, 1'b0, 16'h0000);
    expect_idle("midrst_idle");
  endtask

  task automatic test_ignore_while_busy();
    load(16'h5A5A);
    stream(16'h5A5A, 16, 9, 2, 1'b1, 1'b0, 16'h0000);
    expect_idle("busy_idle");
    checks++; if (mux_din0 !== 16'h5A5A || mux_din1 !== 16'h5A5A) begin failures++; $display("FAIL busy_mux_din got %h/%h want 5a5a", mux_din0, mux_din1); end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_ignore_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
